// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and request-scan helpers for elevator controllers
package elevator_pkg;

    localparam int MAX_FLOORS = 64;

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} elev_state_t;
    typedef enum logic {UP, DN} elev_dir_t;

    function automatic logic any_above(input logic [MAX_FLOORS-1:0] mask, input int idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++)
            if (i > idx && mask[i]) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic any_below(input logic [MAX_FLOORS-1:0] mask, input int idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++)
            if (i < idx && mask[i]) hit = 1'b1;
        return hit;
    endfunction

endpackage

// File: rtl/elevator_scan_ctrl_timer.sv
// rtl/elevator_scan_ctrl_timer.sv - loadable down-counter with zero flag
module elev_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// rtl/elevator_scan_ctrl.sv - single-car SCAN-order elevator controller
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = 4,
    parameter int MOVE_CYCLES = 8,
    parameter int DOOR_CYCLES = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_FLOORS-1:0]                  req,
    output logic [$clog2(NUM_FLOORS)-1:0]          floor,
    output logic                                   moving_up,
    output logic                                   moving_dn,
    output logic                                   door_open,
    output logic                                   idle,
    output logic [NUM_FLOORS-1:0]                  pending
);

    localparam int FW   = $clog2(NUM_FLOORS);
    localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);

    elev_state_t state, nxt_state;
    elev_dir_t   dir, nxt_dir;
    logic [FW-1:0]           nxt_floor, nfloor;
    logic [NUM_FLOORS-1:0]   clr, door_mask;
    logic [MAX_FLOORS-1:0]   pend_ext;
    logic                    above, below, here, ahead_next;
    logic                    tmr_load, tmr_zero;
    logic [TW-1:0]           tmr_val;

    elev_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign pend_ext   = MAX_FLOORS'(pending);
    assign above      = any_above(pend_ext, int'(floor));
    assign below      = any_below(pend_ext, int'(floor));
    assign here       = pending[floor];
    assign nfloor     = (dir == UP) ? floor + 1'b1 : floor - 1'b1;
    assign ahead_next = (dir == UP) ? any_above(pend_ext, int'(nfloor))
                                    : any_below(pend_ext, int'(nfloor));

    always_comb begin
        nxt_state = state;
        nxt_dir   = dir;
        nxt_floor = floor;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        clr       = '0;
        door_mask = '0;
        case (state)
            IDLE: begin
                if (here) begin
                    nxt_state  = DOOR;
                    tmr_load   = 1'b1;
                    tmr_val    = DOOR_LOAD;
                    clr[floor] = 1'b1;
                end else if ((dir == UP && above) || (dir == DN && below)) begin
                    nxt_state = MOVE;
                    tmr_load  = 1'b1;
                    tmr_val   = MOVE_LOAD;
                end else if (above || below) begin
                    nxt_state = MOVE;
                    nxt_dir   = (dir == UP) ? DN : UP;
                    tmr_load  = 1'b1;
                    tmr_val   = MOVE_LOAD;
                end
            end
            MOVE: begin
                // Arrival decision is made against the floor being entered.
                if (tmr_zero) begin
                    nxt_floor = nfloor;
                    if (pending[nfloor]) begin
                        nxt_state   = DOOR;
                        tmr_load    = 1'b1;
                        tmr_val     = DOOR_LOAD;
                        clr[nfloor] = 1'b1;
                    end else if (ahead_next) begin
                        tmr_load = 1'b1;
                        tmr_val  = MOVE_LOAD;
                    end else begin
                        nxt_state = IDLE;
                    end
                end
            end
            DOOR: begin
                // Button for the open floor extends the dwell instead of queueing.
                door_mask[floor] = 1'b1;
                if (req[floor]) begin
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LOAD;
                end else if (tmr_zero) begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dir       <= UP;
            floor     <= '0;
            pending   <= '0;
            moving_up <= 1'b0;
            moving_dn <= 1'b0;
            door_open <= 1'b0;
            idle      <= 1'b1;
        end else begin
            state     <= nxt_state;
            dir       <= nxt_dir;
            floor     <= nxt_floor;
            pending   <= (pending | (req & ~door_mask)) & ~clr;
            moving_up <= (nxt_state == MOVE) && (nxt_dir == UP);
            moving_dn <= (nxt_state == MOVE) && (nxt_dir == DN);
            door_open <= (nxt_state == DOOR);
            idle      <= (nxt_state == IDLE);
        end
    end

    a_one_status: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot({moving_up, moving_dn, door_open, idle}));

    a_floor_range: assert property (@(posedge clk) disable iff (!rst_n)
        (state == MOVE && tmr_zero) |->
            ((dir == UP) ? (floor != FW'(NUM_FLOORS - 1)) : (floor != '0)));

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb/tb_elevator_scan_ctrl.sv - self-checking bench for elevator_scan_ctrl
module tb_elevator_scan_ctrl;

    localparam int NF = 4;
    localparam int MC = 3;
    localparam int DC = 2;
    localparam int FW = $clog2(NF);

    localparam int S_REST   = 0;
    localparam int S_TRAVEL = 1;
    localparam int S_DWELL  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NF-1:0] req = '0;
    logic [FW-1:0] floor;
    logic          moving_up, moving_dn, door_open, idle;
    logic [NF-1:0] pending;

    int vectors = 0;
    int miscompares = 0;
    int door_log[$];

    int m_fl, m_up, m_act, m_left;
    bit m_p [NF];

    elevator_scan_ctrl #(
        .NUM_FLOORS  (NF),
        .MOVE_CYCLES (MC),
        .DOOR_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .floor     (floor),
        .moving_up (moving_up),
        .moving_dn (moving_dn),
        .door_open (door_open),
        .idle      (idle),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_any(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            if (i >= 0 && i < NF && m_p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NF-1:0] m_pend();
        logic [NF-1:0] v;
        for (int i = 0; i < NF; i++) v[i] = m_p[i];
        return v;
    endfunction

    task automatic model_reset();
        m_fl = 0; m_up = 1; m_act = S_REST; m_left = 0;
        for (int i = 0; i < NF; i++) m_p[i] = 1'b0;
    endtask

    // m_left counts cycles still to spend in the current travel segment or dwell.
    task automatic model_step(input logic [NF-1:0] r);
        bit np [NF];
        int nf;
        for (int i = 0; i < NF; i++)
            np[i] = m_p[i] | (r[i] && !(m_act == S_DWELL && i == m_fl));
        case (m_act)
            S_REST: begin
                if (m_p[m_fl]) begin
                    m_act = S_DWELL; m_left = DC; np[m_fl] = 1'b0;
                end else if (m_up == 1 ? m_any(m_fl + 1, NF - 1) : m_any(0, m_fl - 1)) begin
                    m_act = S_TRAVEL; m_left = MC;
                end else if (m_any(0, NF - 1)) begin
                    m_up = (m_up == 1) ? 0 : 1; m_act = S_TRAVEL; m_left = MC;
                end
            end
            S_TRAVEL: begin
                m_left--;
                if (m_left == 0) begin
                    nf = (m_up == 1) ? m_fl + 1 : m_fl - 1;
                    m_fl = nf;
                    if (m_p[nf]) begin
                        m_act = S_DWELL; m_left = DC; np[nf] = 1'b0;
                    end else if (m_up == 1 ? m_any(nf + 1, NF - 1) : m_any(0, nf - 1)) begin
                        m_left = MC;
                    end else begin
                        m_act = S_REST;
                    end
                end
            end
            S_DWELL: begin
                if (r[m_fl]) m_left = DC;
                else begin
                    m_left--;
                    if (m_left == 0) m_act = S_REST;
                end
            end
            default: ;
        endcase
        m_p = np;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step(req);
    end

    always @(negedge clk) begin
        chk("floor", int'(floor), m_fl);
        chk("moving_up", int'(moving_up), (m_act == S_TRAVEL && m_up == 1) ? 1 : 0);
        chk("moving_dn", int'(moving_dn), (m_act == S_TRAVEL && m_up == 0) ? 1 : 0);
        chk("door_open", int'(door_open), (m_act == S_DWELL) ? 1 : 0);
        chk("idle", int'(idle), (m_act == S_REST) ? 1 : 0);
        chk("pending", int'(pending), int'(m_pend()));
    end

    task automatic pulse(input logic [NF-1:0] v);
        req = v;
        @(negedge clk);
        req = '0;
    endtask

    task automatic wait_floor(input int f, input string nm);
        int n = 0;
        while (int'(floor) != f && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(floor), f);
    endtask

    task automatic wait_quiet(input string nm);
        int n = 0;
        while (!(m_act == S_REST && m_pend() == '0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(nm, int'(idle), 1);
    endtask

    task automatic trace_doors(input int ncyc);
        logic prev;
        door_log.delete();
        prev = door_open;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (door_open && !prev) door_log.push_back(int'(floor));
            prev = door_open;
        end
    endtask

    initial begin
        int ups, doors, first_up;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_idle", int'(idle), 1);
        chk("rst_floor", int'(floor), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_door", int'(door_open), 0);
        rst_n = 1'b1;

        // single trip 0 -> 2
        pulse(4'b0100);
        chk("trip_latched", int'(pending), 4'b0100);
        chk("trip_wait_idle", int'(idle), 1);
        ups = 0; doors = 0; first_up = -1;
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk);
            if (moving_up) begin
                ups++;
                if (first_up < 0) first_up = k;
            end
            if (door_open) doors++;
        end
        chk("trip_up_cycles", ups, 6);
        chk("trip_door_cycles", doors, 2);
        chk("trip_first_up", first_up, 2);
        chk("trip_floor", int'(floor), 2);
        chk("trip_idle", int'(idle), 1);

        // current-floor request then door extend on last dwell cycle
        pulse(4'b0100);
        @(negedge clk);
        chk("here_door", int'(door_open), 1);
        chk("here_floor", int'(floor), 2);
        chk("here_pend", int'(pending), 0);
        @(negedge clk);
        chk("ext_last_dwell", int'(door_open), 1);
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        chk("ext_door1", int'(door_open), 1);
        chk("ext_pend", int'(pending[2]), 0);
        @(negedge clk);
        chk("ext_door2", int'(door_open), 1);
        @(negedge clk);
        chk("ext_closed", int'(idle), 1);

        // go to floor 0, leaving direction DN
        pulse(4'b0001);
        wait_quiet("to0_quiet");
        chk("to0_floor", int'(floor), 0);

        // SCAN order: upward request at 3 finishes before the 0 request
        pulse(4'b1000);
        wait_floor(1, "scan_reach1");
        chk("scan_up_at1", int'(moving_up), 1);
        chk("scan_pend_at1", int'(pending), 4'b1000);
        pulse(4'b0001);
        trace_doors(60);
        chk("scan_ndoors", door_log.size(), 2);
        chk("scan_first", door_log.size() > 0 ? door_log[0] : -1, 3);
        chk("scan_second", door_log.size() > 1 ? door_log[1] : -1, 0);
        chk("scan_pend_end", int'(pending), 0);

        // all floors at once from floor 0
        pulse(4'b1111);
        trace_doors(60);
        chk("multi_ndoors", door_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("multi_order", door_log.size() > i ? door_log[i] : -1, i);
        chk("multi_floor", int'(floor), 3);
        chk("multi_idle", int'(idle), 1);

        // asynchronous reset mid-move at floor 2
        pulse(4'b0001);
        wait_floor(2, "rst_reach2");
        chk("rst_mid_moving", int'(moving_dn), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_floor", int'(floor), 0);
        chk("arst_idle", int'(idle), 1);
        chk("arst_pending", int'(pending), 0);
        chk("arst_moving", int'(moving_dn), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic against the model
        for (int k = 0; k < 500; k++) begin
            req = ($urandom_range(0, 4) == 0) ? NF'($urandom) : '0;
            @(negedge clk);
        end
        req = '0;
        wait_quiet("rand_quiet");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
